// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiply sequencer: FSM state encoding,
// default operand width and the iteration-counter width.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mult_state_e;

  // Counter must reach WIDTH-1; keep at least one bit for degenerate widths.
  function automatic int mult_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MULT_CNT_W = mult_cnt_w(MULT_WIDTH);

endpackage

// File: rtl/mult_if.sv
// Execute-stage <-> multiply sequencer bundle: operation request, HI/LO read
// hazard, flush, and the sequencer's status/result outputs.
interface mult_if #(
  parameter int WIDTH = mult_pkg::MULT_WIDTH
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             rd_hilo;
  logic             kill;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sign, srca, srcb, rd_hilo, kill,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, sign, srca, srcb, rd_hilo, kill,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: magnitude operands, shadow accumulator and the
// optional final two's-complement negate of the product.
import mult_pkg::*;

module mult_shift_add #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               negate_i,
  input  logic               sign_i,
  input  logic [WIDTH-1:0]   srca_i,
  input  logic [WIDTH-1:0]   srcb_i,
  output logic [2*WIDTH-1:0] prod_o
);

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     upper_sum;
  logic [WIDTH:0]     upper_nxt;
  logic [2*WIDTH:0]   acc_wide;

  // Carry out of the upper-half add lands in the MSB after the shift.
  assign upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign upper_nxt = mplier_q[0] ? upper_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign acc_wide  = {upper_nxt, acc_q[WIDTH-1:0]};

  assign prod_o = negate_i ? (~acc_q + 1'b1) : acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= abs_op(srca_i, sign_i);
      mplier_q <= abs_op(srcb_i, sign_i);
      acc_q    <= '0;
    end else if (step_i) begin
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_wide[2*WIDTH:1];
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Execute-stage multiply sequencer: owns HI/LO, steps the shift-add datapath
// for WIDTH cycles, then fixes the sign, and stalls dependent instructions.
import mult_pkg::*;

module mult_sequencer #(
  parameter int WIDTH = MULT_WIDTH
) (
  input logic   clk,
  input logic   reset,
  mult_if.slave bus
);

  localparam int CNT_W = mult_cnt_w(WIDTH);

  mult_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               load;
  logic               step;
  logic               commit;
  logic [2*WIDTH-1:0] prod;

  // A flush overrides everything: no accept, no step, no commit.
  assign load   = (state_q == ST_IDLE) && bus.start && !bus.kill;
  assign step   = (state_q == ST_RUN)  && !bus.kill;
  assign commit = (state_q == ST_FIX)  && !bus.kill;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          neg_d   = bus.sign & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
        end
      end
      ST_RUN: begin
        if (bus.kill) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  mult_shift_add #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .step_i   (step),
    .negate_i (neg_q),
    .sign_i   (bus.sign),
    .srca_i   (bus.srca),
    .srcb_i   (bus.srcb),
    .prod_o   (prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= commit;
      if (commit) begin
        hi_q <= prod[2*WIDTH-1:WIDTH];
        lo_q <= prod[WIDTH-1:0];
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.stall = busy_q & (bus.start | bus.rd_hilo);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: a cycle-level reference model predicts
// busy/stall/done and HI/LO from plain 64-bit products.
module tb_mult_sequencer;
  import mult_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mult_if #(.WIDTH(W)) bus ();

  mult_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           active = 1'b0;
  int           end_cyc = 0;
  int           done_cyc = -1;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic signed [2*W-1:0] sa, sb, sp;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      sp = sa * sb;
      return sp;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one multiply occupies WIDTH+1 clock edges after acceptance.
  initial begin
    logic [2*W-1:0] p;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        active   = 1'b0;
        sb_q.delete();
        m_hi     = '0;
        m_lo     = '0;
        done_cyc = -1;
      end else begin
        if (active) begin
          if (bus.kill) begin
            active = 1'b0;
            if (sb_q.size() > 0) void'(sb_q.pop_back());
          end else if (cyc == end_cyc) begin
            active = 1'b0;
            if (sb_q.size() > 0) begin
              m_hi = sb_q[$].hi;
              m_lo = sb_q[$].lo;
            end
            done_cyc = cyc + 1;
          end
        end else if (bus.start && !bus.kill) begin
          p = ref_mul(bus.srca, bus.srcb, bus.sign);
          sb_q.push_back('{hi: p[2*W-1:W], lo: p[W-1:0]});
          active  = 1'b1;
          end_cyc = cyc + 1 + W;
        end
        cyc++;
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("busy", 64'(bus.busy), 64'(active));
      chk("stall", 64'(bus.stall), 64'(active & (bus.start | bus.rd_hilo)));
      chk("done", 64'(bus.done), 64'(reset && (cyc == done_cyc)));
      if (bus.done) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected: got done=1, expected no pending result (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("sb_hi", 64'(bus.hi), 64'(e.hi));
          chk("sb_lo", 64'(bus.lo), 64'(e.lo));
        end
      end
      chk("hold_hi", 64'(bus.hi), 64'(m_hi));
      chk("hold_lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds start like a stalled execute stage until the sequencer takes it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bit ok;
    ok        = 1'b0;
    bus.start = 1'b1;
    bus.sign  = s;
    bus.srca  = a;
    bus.srcb  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.stall) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout: got stall=1 for 200 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sign  = 1'($urandom);
    bus.srca  = $urandom;
    bus.srcb  = $urandom;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start   = 1'b0;
    bus.sign    = 1'b0;
    bus.srca    = '0;
    bus.srcb    = '0;
    bus.rd_hilo = 1'b0;
    bus.kill    = 1'b0;

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b1;
    idle(2);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(W + 1);
    chk("umax_done", 64'(bus.done), 64'd1);
    chk("umax_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    chk("umax_lo", 64'(bus.lo), 64'h0000_0001);
    idle(1);
    chk("umax_done_pulse", 64'(bus.done), 64'd0);

    issue(32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
    idle(W + 1);
    chk("smix_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("smix_lo", 64'(bus.lo), 64'hFFFF_FFF1);

    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    idle(W + 1);
    chk("scorner_hi", 64'(bus.hi), 64'h4000_0000);
    chk("scorner_lo", 64'(bus.lo), 64'h0000_0000);

    // MFLO parked behind a multiply sees the old value until the result lands.
    issue(32'd1234, 32'd5678, 1'b0);
    bus.rd_hilo = 1'b1;
    idle(W);
    chk("haz_stall_fix", 64'(bus.stall), 64'd1);
    chk("haz_lo_old", 64'(bus.lo), 64'd0);
    idle(1);
    chk("haz_stall_rel", 64'(bus.stall), 64'd0);
    chk("haz_lo_new", 64'(bus.lo), 64'(32'd1234 * 32'd5678));
    bus.rd_hilo = 1'b0;

    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    issue(32'hFFFF_FF00, 32'h7FFF_FFFF, 1'b1);
    idle(W + 2);

    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    idle(9);
    bus.kill = 1'b1;
    idle(1);
    bus.kill = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    idle(W + 3);

    issue(32'h0000_0777, 32'h0000_0999, 1'b0);
    idle(W);
    bus.kill = 1'b1;
    idle(1);
    bus.kill = 1'b0;
    idle(3);

    bus.kill  = 1'b1;
    bus.start = 1'b1;
    idle(1);
    bus.kill  = 1'b0;
    bus.start = 1'b0;
    chk("kill_start_idle", 64'(bus.busy), 64'd0);
    idle(2);

    for (int n = 0; n < 60; n++) begin
      int gap;
      issue(pick(), pick(), 1'($urandom));
      gap = $urandom_range(0, W + 4);
      repeat (gap) begin
        bus.rd_hilo = 1'($urandom);
        bus.kill    = (($urandom % 40) == 0);
        idle(1);
      end
      bus.kill    = 1'b0;
      bus.rd_hilo = 1'b0;
    end
    idle(W + 3);

    // Asynchronous reset in the middle of an operation.
    issue(32'hCAFE_F00D, 32'h1357_9BDF, 1'b0);
    idle(5);
    #2 reset = 1'b0;
    bus.rd_hilo = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_hi", 64'(bus.hi), 64'd0);
    chk("arst_lo", 64'(bus.lo), 64'd0);
    chk("arst_stall", 64'(bus.stall), 64'd0);
    bus.rd_hilo = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    issue(32'd7, 32'd6, 1'b0);
    idle(W + 1);
    chk("post_rst_hi", 64'(bus.hi), 64'd0);
    chk("post_rst_lo", 64'(bus.lo), 64'd42);

    idle(3);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
